// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone classic arbiter with round-robin grant,
// CYC-based locking and a per-transfer ACK watchdog.
module wb_rr_arbiter #(
    parameter int XLEN        = 32,
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS*XLEN-1:0]   m_adr,
    input  logic [NUM_MASTERS*XLEN-1:0]   m_dat_w,
    input  logic [NUM_MASTERS*XLEN/8-1:0] m_sel,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS-1:0]        m_stb,
    input  logic [NUM_MASTERS-1:0]        m_cyc,
    output logic [XLEN-1:0]               m_dat_r,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [NUM_MASTERS-1:0]        m_err,
    output logic [XLEN-1:0]               s_adr,
    output logic [XLEN-1:0]               s_dat_w,
    output logic [XLEN/8-1:0]             s_sel,
    output logic                          s_we,
    output logic                          s_stb,
    output logic                          s_cyc,
    input  logic [XLEN-1:0]               s_dat_r,
    input  logic                          s_ack
);

    localparam int SW      = XLEN / 8;
    localparam int GW      = $clog2(NUM_MASTERS);
    localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_last;
    logic [CW-1:0]   r_wd_cnt;

    logic [GW-1:0]   w_next_grant;
    logic            w_stb;
    logic            w_expire;

    // Descending scan so the nearest requester after r_last is written last.
    always_comb begin
        w_next_grant = '0;
        for (int unsigned k = NUM_MASTERS; k >= 1; k--) begin
            if (m_cyc[GW'((32'(r_last) + k) % NUM_MASTERS)])
                w_next_grant = GW'((32'(r_last) + k) % NUM_MASTERS);
        end
    end

    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_w  = '0;
        s_sel    = '0;
        m_ack    = '0;
        m_err    = '0;
        m_dat_r  = '0;
        w_stb    = 1'b0;
        w_expire = 1'b0;
        if (r_state == BUSY) begin
            w_stb    = m_stb[r_grant] & m_cyc[r_grant];
            w_expire = (TIMEOUT > 0) && w_stb && !s_ack && (r_wd_cnt == CW'(WD_LAST));
            s_adr    = m_adr[r_grant*XLEN +: XLEN];
            s_dat_w  = m_dat_w[r_grant*XLEN +: XLEN];
            s_sel    = m_sel[r_grant*SW +: SW];
            s_we     = m_we[r_grant];
            s_cyc    = m_cyc[r_grant] & ~w_expire;
            s_stb    = w_stb & ~w_expire;
            m_ack[r_grant] = s_ack & w_stb;
            m_err[r_grant] = w_expire;
            m_dat_r  = s_dat_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_last   <= GW'(NUM_MASTERS - 1);
            r_wd_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wd_cnt <= '0;
                    if (|m_cyc) begin
                        r_grant <= w_next_grant;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!m_cyc[r_grant]) begin
                        r_last   <= r_grant;
                        r_state  <= IDLE;
                        r_wd_cnt <= '0;
                    end else if (w_expire) begin
                        r_state  <= DRAIN;
                        r_wd_cnt <= '0;
                    end else if ((TIMEOUT > 0) && w_stb && !s_ack) begin
                        r_wd_cnt <= r_wd_cnt + CW'(1);
                    end else begin
                        r_wd_cnt <= '0;
                    end
                end
                DRAIN: begin
                    r_wd_cnt <= '0;
                    if (!m_cyc[r_grant]) begin
                        r_last  <= r_grant;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios plus random traffic, all
// checked against a cycle-level ownership model.
module tb_wb_rr_arbiter;

    localparam int XL = 32;
    localparam int NM = 3;
    localparam int TO = 4;
    localparam int SW = XL / 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NM*XL-1:0]      m_adr, m_dat_w;
    logic [NM*SW-1:0]      m_sel;
    logic [NM-1:0]         m_we, m_stb, m_cyc;
    logic [XL-1:0]         m_dat_r;
    logic [NM-1:0]         m_ack, m_err;
    logic [XL-1:0]         s_adr, s_dat_w;
    logic [SW-1:0]         s_sel;
    logic                  s_we, s_stb, s_cyc;
    logic [XL-1:0]         s_dat_r;
    logic                  s_ack;

    int total = 0;
    int bad   = 0;

    // model: current owner (-1 = none), drain flag, last owner, stall counter
    int mdl_owner, mdl_drain, mdl_last, mdl_wait;

    logic [NM-1:0] obs_ack, obs_err;
    logic          obs_scyc;
    logic [XL-1:0] obs_sadr, obs_dr;

    wb_rr_arbiter #(.XLEN(XL), .NUM_MASTERS(NM), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel),
        .m_we(m_we), .m_stb(m_stb), .m_cyc(m_cyc),
        .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
        .s_we(s_we), .s_stb(s_stb), .s_cyc(s_cyc),
        .s_dat_r(s_dat_r), .s_ack(s_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Requester with the smallest rotational distance past the last owner.
    function automatic int rr_pick(input logic [NM-1:0] req, input int last);
        int best = -1;
        int bestd = NM + 1;
        for (int i = 0; i < NM; i++) begin
            if (req[i] && ((i - last - 1 + NM) % NM) < bestd) begin
                bestd = (i - last - 1 + NM) % NM;
                best  = i;
            end
        end
        return best;
    endfunction

    task automatic mdl_reset();
        mdl_owner = -1;
        mdl_drain = 0;
        mdl_last  = NM - 1;
        mdl_wait  = 0;
    endtask

    // Compare one cycle at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        logic [NM-1:0] e_ack, e_err;
        logic          e_cyc, e_stb, e_we, raw, expd;
        logic [XL-1:0] e_adr, e_dw, e_dr;
        logic [SW-1:0] e_sel;
        int g;
        @(negedge clk);
        e_ack = '0; e_err = '0; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
        e_adr = '0; e_dw = '0; e_dr = '0; e_sel = '0; raw = 1'b0; expd = 1'b0;
        if (mdl_owner >= 0 && mdl_drain == 0) begin
            g      = mdl_owner;
            raw    = m_stb[g] & m_cyc[g];
            expd   = raw && !s_ack && (mdl_wait == TO - 1);
            e_cyc  = m_cyc[g] && !expd;
            e_stb  = raw && !expd;
            e_we   = m_we[g];
            e_adr  = m_adr[g*XL +: XL];
            e_dw   = m_dat_w[g*XL +: XL];
            e_sel  = m_sel[g*SW +: SW];
            e_ack[g] = s_ack & raw;
            e_err[g] = expd;
            e_dr   = s_dat_r;
        end
        check("s_cyc", s_cyc, e_cyc);
        check("s_stb", s_stb, e_stb);
        check("s_we", s_we, e_we);
        check("s_adr", s_adr, e_adr);
        check("s_dat_w", s_dat_w, e_dw);
        check("s_sel", s_sel, e_sel);
        check("m_ack", m_ack, e_ack);
        check("m_err", m_err, e_err);
        check("m_dat_r", m_dat_r, e_dr);
        obs_ack = m_ack; obs_err = m_err; obs_scyc = s_cyc;
        obs_sadr = s_adr; obs_dr = m_dat_r;
        @(posedge clk);
        if (rst) begin
            mdl_reset();
        end else if (mdl_owner < 0) begin
            if (|m_cyc) begin
                mdl_owner = rr_pick(m_cyc, mdl_last);
                mdl_wait  = 0;
            end
        end else if (!m_cyc[mdl_owner]) begin
            mdl_last  = mdl_owner;
            mdl_owner = -1;
            mdl_drain = 0;
            mdl_wait  = 0;
        end else if (mdl_drain == 0) begin
            if (expd) begin
                mdl_drain = 1;
                mdl_wait  = 0;
            end else if (raw && !s_ack) begin
                mdl_wait++;
            end else begin
                mdl_wait = 0;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        m_adr = '0; m_dat_w = '0; m_sel = '0;
        m_we = '0; m_stb = '0; m_cyc = '0;
        s_dat_r = '0; s_ack = 1'b0;
    endtask

    task automatic drv(input int i, input logic cyc, input logic stb, input logic [XL-1:0] adr);
        m_cyc[i] = cyc;
        m_stb[i] = stb;
        m_we[i]  = 1'b0;
        m_adr[i*XL +: XL]   = adr;
        m_dat_w[i*XL +: XL] = adr ^ 32'h5A5A_0000;
        m_sel[i*SW +: SW]   = '1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int order[$];
        int when[$];
        logic [XL-1:0] adrs[$];
        int leak;
        int got0;

        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        mdl_reset();
        rst = 1'b0;

        // reset state
        cycle();
        check("rst_scyc", obs_scyc, 0);
        check("rst_ack", obs_ack, 0);
        check("rst_err", obs_err, 0);

        // single master, slave acks one cycle later
        drv(0, 1, 1, 32'h100);
        cycle();
        check("sm_idle_scyc", obs_scyc, 0);
        cycle();
        check("sm_scyc", obs_scyc, 1);
        check("sm_noack", obs_ack, 0);
        s_ack = 1'b1; s_dat_r = 32'hDEAD_BEEF;
        cycle();
        check("sm_ack", obs_ack, 3'b001);
        check("sm_dat", obs_dr, 32'hDEAD_BEEF);
        drv(0, 0, 0, 32'h100); s_ack = 1'b0;
        cycle();
        check("sm_drop", obs_scyc, 0);

        // contention between masters 0 and 1
        do_reset();
        drv(0, 1, 1, 32'h1000);
        drv(1, 1, 1, 32'h2000);
        s_ack = 1'b1;
        for (int n = 0; n < 60 && order.size() < 8; n++) begin
            cycle();
            for (int i = 0; i < 2; i++) begin
                if (obs_ack[i]) begin
                    order.push_back(i);
                    when.push_back(n);
                    m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
                end else if (!m_cyc[i]) begin
                    m_cyc[i] = 1'b1; m_stb[i] = 1'b1;
                end
            end
        end
        check("ctn_count", order.size(), 8);
        for (int k = 0; k < order.size(); k++) check("ctn_order", order[k], k % 2);
        for (int k = 1; k < when.size(); k++) check("ctn_gap", when[k] - when[k-1], 3);

        // locked burst by master 1 while master 0 waits
        do_reset();
        drv(1, 1, 1, 32'h200);
        s_ack = 1'b1;
        cycle();
        drv(0, 1, 1, 32'h300);
        leak = 0; got0 = 0;
        for (int n = 0; n < 30 && got0 == 0; n++) begin
            logic held;
            held = m_cyc[1];
            cycle();
            if (held && obs_scyc && obs_sadr == 32'h300) leak++;
            if (obs_ack[1]) begin
                adrs.push_back(obs_sadr);
                if (adrs.size() == 3) drv(1, 0, 0, 32'h0);
                else m_adr[1*XL +: XL] = m_adr[1*XL +: XL] + 32'd4;
            end
            if (obs_ack[0]) got0 = 1;
        end
        check("bst_count", adrs.size(), 3);
        for (int k = 0; k < adrs.size(); k++) check("bst_adr", adrs[k], 32'h200 + 32'(4 * k));
        check("bst_leak", leak, 0);
        check("bst_m0_served", got0, 1);

        // watchdog expiry
        do_reset();
        drv(0, 1, 1, 32'h400);
        cycle();
        for (int k = 1; k <= 4; k++) begin
            cycle();
            check("wd_err", obs_err, (k == 4) ? 3'b001 : 3'b000);
            check("wd_scyc", obs_scyc, (k == 4) ? 0 : 1);
        end
        s_ack = 1'b1;
        repeat (3) begin
            cycle();
            check("drn_scyc", obs_scyc, 0);
            check("drn_ack", obs_ack, 0);
            check("drn_err", obs_err, 0);
        end
        drv(0, 0, 0, 32'h400); s_ack = 1'b0;
        cycle();
        cycle();
        check("drn_exit", obs_scyc, 0);

        // ack arrives exactly on the expiry cycle
        drv(0, 1, 1, 32'h404);
        cycle();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) s_ack = 1'b1;
            cycle();
            check("wda_err", obs_err, 0);
            if (k == 4) check("wda_ack", obs_ack, 3'b001);
        end
        drv(0, 0, 0, 32'h0); s_ack = 1'b0;
        cycle();

        // last=0, masters 0 and 2 request: master 2 first
        drv(0, 1, 1, 32'h500);
        drv(2, 1, 1, 32'h700);
        cycle();
        cycle();
        check("rr3_adr", obs_sadr, 32'h700);
        check("rr3_scyc", obs_scyc, 1);

        // reset in the middle of master 2's transfer
        rst = 1'b1;
        cycle();
        rst = 1'b0; s_ack = 1'b1;
        cycle();
        check("mrst_scyc", obs_scyc, 0);
        check("mrst_ack", obs_ack, 0);
        check("mrst_err", obs_err, 0);
        cycle();
        check("mrst_first", obs_ack, 3'b001);

        // random traffic
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NM; i++) begin
                if ($urandom_range(7) == 0) m_cyc[i] = ~m_cyc[i];
                m_stb[i] = ($urandom_range(3) != 0);
                m_we[i]  = 1'($urandom_range(1));
                m_adr[i*XL +: XL]   = $urandom;
                m_dat_w[i*XL +: XL] = $urandom;
                m_sel[i*SW +: SW]   = SW'($urandom_range(15));
            end
            s_ack   = ($urandom_range(2) == 0);
            s_dat_r = $urandom;
            rst     = ($urandom_range(499) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
